// File: rtl/lsu_mem_ctrl.sv
// Load/store unit front-end: accepts one core request at a time, aligns and extends loads,
// and performs read-modify-write for sub-word stores against a single-port word memory.
module lsu_mem_ctrl #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [7:0]  err_count,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wrData,
  output logic        mem_wrMem,
  output logic        mem_rdMem,
  input  logic [31:0] mem_rdData
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  // Only the fields needed after accept are kept; word stores write req_wdata directly.
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [MEM_AW+1:0] addr;
    logic [15:0]       wdata;
  } req_t;

  state_t state;
  req_t   lat;

  logic                 req_bad;
  logic [31:0]          ld_data;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [NUM_LANES-1:0] st_en;
  logic [31:0]          st_rep;
  logic [31:0]          merged;
  logic [31:0]          new_idx;
  logic [31:0]          lat_idx;

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
    if (req_addr[31:MEM_AW+2] != '0) req_bad = 1'b1;
  end

  assign new_idx = {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
  assign lat_idx = {{(32-MEM_AW){1'b0}}, lat.addr[MEM_AW+1:2]};

  always_comb begin
    ld_byte = mem_rdData[7:0];
    case (lat.addr[1:0])
      2'd1:    ld_byte = mem_rdData[15:8];
      2'd2:    ld_byte = mem_rdData[23:16];
      2'd3:    ld_byte = mem_rdData[31:24];
      default: ld_byte = mem_rdData[7:0];
    endcase
    ld_half = lat.addr[1] ? mem_rdData[31:16] : mem_rdData[15:0];
    case (lat.size)
      2'b00:   ld_data = {{24{~lat.uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~lat.uns & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdData;
    endcase
  end

  // Byte-enable mask and replicated store data for the merge into the old word.
  always_comb begin
    if (lat.size == 2'b00) begin
      st_en  = 4'b0001 << lat.addr[1:0];
      st_rep = {4{lat.wdata[7:0]}};
    end else begin
      st_en  = lat.addr[1] ? 4'b1100 : 4'b0011;
      st_rep = {2{lat.wdata}};
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = st_en[i] ? st_rep[8*i +: 8] : mem_rdData[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
      mem_addr   <= '0;
      mem_wrData <= '0;
      mem_wrMem  <= 1'b0;
      mem_rdMem  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      mem_rdMem  <= 1'b0;
      mem_wrMem  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat       <= '{we: req_we, size: req_size, uns: req_unsigned,
                           addr: req_addr[MEM_AW+1:0], wdata: req_wdata[15:0]};
            req_ready <= 1'b0;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (req_we && req_size == 2'b10) begin
              state      <= WR;
              mem_wrMem  <= 1'b1;
              mem_wrData <= req_wdata;
              mem_addr   <= new_idx;
            end else begin
              state     <= RD;
              mem_rdMem <= 1'b1;
              mem_addr  <= new_idx;
            end
          end
        end
        RD: begin
          state    <= RD_WAIT;
          mem_addr <= lat_idx;
        end
        RD_WAIT: begin
          if (lat.we) begin
            state      <= WR;
            mem_wrMem  <= 1'b1;
            mem_wrData <= merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= ld_data;
            mem_addr   <= '0;
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= '0;
          mem_addr   <= '0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          resp_err  <= 1'b0;
          resp_data <= '0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_addr  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word memory attached.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [7:0]  err_count;
  logic [31:0] mem_addr, mem_wrData, mem_rdData;
  logic        mem_wrMem, mem_rdMem;

  int total = 0, passed = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rv_cnt = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_AW(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .err_count(err_count),
    .mem_addr(mem_addr), .mem_wrData(mem_wrData), .mem_wrMem(mem_wrMem),
    .mem_rdMem(mem_rdMem), .mem_rdData(mem_rdData)
  );

  logic [31:0] mem [0:1023];
  always @(posedge clk or posedge rst) begin
    if (rst) mem[0] <= 32'd10;
    else begin
      if (mem_wrMem) mem[mem_addr[9:0]] <= mem_wrData;
      if (mem_rdMem) mem_rdData <= mem[mem_addr[9:0]];
    end
  end

  always @(posedge clk) begin
    if (mem_rdMem) rd_cnt++;
    if (mem_wrMem) wr_cnt++;
    if (mem_rdMem && mem_wrMem) both_cnt++;
    if (resp_valid) rv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  int          lat, drd, dwr;
  logic [31:0] rdata;
  logic        rerr;

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n, r0, w0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    lat = n; rdata = resp_data; rerr = resp_err;
    drd = rd_cnt - r0; dwr = wr_cnt - w0;
  endtask

  int w0, rv0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, mem_rdMem, mem_wrMem}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("ldw0_lat", lat, 2); chk("ldw0_data", rdata, 32'd10);
    chk("ldw0_err", {31'd0, rerr}, 0); chk("ldw0_rd", drd, 1); chk("ldw0_wr", dwr, 0);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8000_00F0);
    chk("stw_lat", lat, 1); chk("stw_rd", drd, 0); chk("stw_wr", dwr, 1);
    chk("stw_mem", mem[4], 32'h8000_00F0); chk("stw_data", rdata, 0);

    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("lb_s", rdata, 32'hFFFF_FFF0); chk("lb_lat", lat, 2);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("lhu", rdata, 32'h0000_8000);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh_s", rdata, 32'hFFFF_8000);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lbu_3", rdata, 32'h0000_0080);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB);
    chk("sb_lat", lat, 3); chk("sb_rd", drd, 1); chk("sb_wr", dwr, 1);
    chk("sb_mem", mem[4], 32'h1122_AB44); chk("sb_err", {31'd0, rerr}, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF);
    chk("sh_mem", mem[4], 32'hBEEF_AB44); chk("sh_lat", lat, 3);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("ldw_after_rmw", rdata, 32'hBEEF_AB44);

    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    chk("e_mis_lat", lat, 0); chk("e_mis_err", {31'd0, rerr}, 1);
    chk("e_mis_data", rdata, 0); chk("e_mis_strb", drd + dwr, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    chk("e_size_lat", lat, 0); chk("e_size_err", {31'd0, rerr}, 1);
    chk("e_size_strb", drd + dwr, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    chk("e_range_lat", lat, 0); chk("e_range_err", {31'd0, rerr}, 1);
    chk("e_range_strb", drd + dwr, 0);
    chk("e_count3", {24'd0, err_count}, 32'd3);

    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h5566_7788);
    @(negedge clk); @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h99;
    w0 = wr_cnt; rv0 = rv_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_low", {31'd0, mem_wrMem}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_wr", wr_cnt - w0, 0);
    chk("mid_rst_no_resp", rv_cnt - rv0, 0);
    chk("mid_rst_mem", mem[8], 32'h5566_7788);
    chk("mid_rst_ready", {31'd0, req_ready}, 1);
    chk("mid_rst_errcnt", {24'd0, err_count}, 0);

    for (int i = 0; i < 300; i++) do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    chk("sat_count", {24'd0, err_count}, 32'd255);
    chk("no_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
